// File: rtl/logic_prim_unit_if.sv
// Operand/result handshake bundle for logic_prim_unit.
interface logic_prim_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_zero;
  logic             y_ones;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, y_zero, y_ones
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, y_zero, y_ones
  );
endinterface

// File: rtl/logic_prim_unit.sv
// Buffered multi-op bitwise unit built from gate primitives, draining through a result FIFO.
// Optional LOGIC_PRIM_PIPE_EN adds a register stage between the gate array and the FIFO.
module logic_prim_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input logic              clk,
  input logic              rst_n,
  logic_prim_unit_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = WIDTH + 2;

  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  assign a_w = bus.a;
  assign b_w = bus.b;

  wire [WIDTH-1:0] g_and, g_or, g_xor, g_nand, g_nor, g_xnor, g_not, g_buf;

  // One primitive per op per bit; the op mux below picks the bit result.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    and  u_and  (g_and[i],  a_w[i], b_w[i]);
    or   u_or   (g_or[i],   a_w[i], b_w[i]);
    xor  u_xor  (g_xor[i],  a_w[i], b_w[i]);
    nand u_nand (g_nand[i], a_w[i], b_w[i]);
    nor  u_nor  (g_nor[i],  a_w[i], b_w[i]);
    xnor u_xnor (g_xnor[i], a_w[i], b_w[i]);
    not  u_not  (g_not[i],  a_w[i]);
    buf  u_buf  (g_buf[i],  a_w[i]);
  end

  logic [WIDTH-1:0] result_c;
  logic [ENT_W-1:0] entry_c;

  always_comb begin
    result_c = '0;
    case (bus.op)
      3'd0:    result_c = g_and;
      3'd1:    result_c = g_or;
      3'd2:    result_c = g_xor;
      3'd3:    result_c = g_nand;
      3'd4:    result_c = g_nor;
      3'd5:    result_c = g_xnor;
      3'd6:    result_c = g_not;
      default: result_c = g_buf;
    endcase
    // Entry layout: {ones, zero, result}; flags frozen at write time.
    entry_c = {&result_c, ~|result_c, result_c};
  end

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] occ;
  logic             accept;
  logic             pop;
  logic             push;
  logic [ENT_W-1:0] push_data;
  logic             fifo_nempty;

`ifdef LOGIC_PRIM_PIPE_EN
  logic [ENT_W-1:0] pipe_q, pipe_d;
  logic             pipe_v_q, pipe_v_d;
  assign occ = cnt_q + CNT_W'(pipe_v_q);
`else
  assign occ = cnt_q;
`endif

  assign fifo_nempty = (cnt_q != '0);
  assign bus.in_ready = (occ < CNT_W'(DEPTH));

  always_comb begin
    accept    = bus.in_valid && bus.in_ready;
    pop       = fifo_nempty && bus.out_ready;
`ifdef LOGIC_PRIM_PIPE_EN
    // Stage drains when the FIFO has room after any same-edge pop.
    push      = pipe_v_q && ((cnt_q < CNT_W'(DEPTH)) || pop);
    push_data = pipe_q;
    pipe_d    = accept ? entry_c : pipe_q;
    pipe_v_d  = accept || (pipe_v_q && !push);
`else
    push      = accept;
    push_data = entry_c;
`endif
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
`ifdef LOGIC_PRIM_PIPE_EN
      pipe_q   <= '0;
      pipe_v_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
`ifdef LOGIC_PRIM_PIPE_EN
      pipe_q   <= pipe_d;
      pipe_v_q <= pipe_v_d;
`endif
    end
  end

  logic [ENT_W-1:0] head;
  assign head          = mem_q[rd_ptr_q];
  assign bus.out_valid = fifo_nempty;
  assign bus.y         = fifo_nempty ? head[WIDTH-1:0] : '0;
  assign bus.y_zero    = fifo_nempty & head[WIDTH];
  assign bus.y_ones    = fifo_nempty & head[WIDTH+1];
endmodule

// File: tb/tb_logic_prim_unit.sv
// Randomised and directed bench for logic_prim_unit against a queue-based reference model.
module tb_logic_prim_unit;
  localparam int unsigned DEPTH = 2;

  logic clk;
  logic rst_n;
  logic_prim_unit_if #(.WIDTH(8)) bus ();

  logic_prim_unit #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [7:0] exp_q[$];
  logic stalled = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  // One clock: drive at negedge, check the held state, advance the model at posedge.
  task automatic cycle(input logic v, input logic [7:0] ai, input logic [7:0] bi,
                       input logic [2:0] opi, input logic ordy, output logic acc);
    logic pop;
    logic [7:0] e;
    bus.in_valid  = v;
    bus.a         = ai;
    bus.b         = bi;
    bus.op        = opi;
    bus.out_ready = ordy;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
`ifndef LOGIC_PRIM_PIPE_EN
    check("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
`endif
    if (stalled) check("stall_valid", 32'(bus.out_valid), 32'd1);
    if (bus.out_valid) begin
      check("head_known", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("y", 32'(bus.y), 32'(e));
        check("y_zero", 32'(bus.y_zero), 32'(e == 8'h00));
        check("y_ones", 32'(bus.y_ones), 32'(e == 8'hFF));
      end
    end else begin
      check("y_idle", 32'({bus.y, bus.y_zero, bus.y_ones}), 32'd0);
    end
    acc     = v && bus.in_ready;
    pop     = bus.out_valid && ordy;
    stalled = bus.out_valid && !ordy;
    @(posedge clk);
    if (pop && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      n_out++;
    end
    if (acc) exp_q.push_back(ref_op(opi, ai, bi));
    @(negedge clk);
  endtask

  task automatic drain();
    logic acc;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic acc;
    logic [7:0] pa, pb;
    logic [2:0] po;
    int acc_cnt;
    int out_start;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out", 32'({bus.out_valid, bus.y, bus.y_zero, bus.y_ones}), 32'd0);
    rst_n = 1'b1;

    // Op sweep at full throughput.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'hC5, 8'h3A, 3'(i), 1'b1, acc);
      check("sweep_acc", 32'(acc), 32'd1);
    end
    drain();

    // Latency from an empty unit.
    cycle(1'b1, 8'h81, 8'h18, 3'd1, 1'b0, acc);
    check("lat_acc", 32'(acc), 32'd1);
`ifdef LOGIC_PRIM_PIPE_EN
    check("lat_first", 32'(bus.out_valid), 32'd0);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, acc);
`endif
    check("lat_valid", 32'(bus.out_valid), 32'd1);
    drain();

    // Backpressure, then full with simultaneous pop.
    cycle(1'b1, 8'h12, 8'h34, 3'd2, 1'b0, acc);
    check("bp_acc0", 32'(acc), 32'd1);
    cycle(1'b1, 8'hF0, 8'h0F, 3'd1, 1'b0, acc);
    check("bp_acc1", 32'(acc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 8'hAA, 8'h55, 3'd5, 1'b0, acc);
      check("bp_held", 32'(acc), 32'd0);
    end
    cycle(1'b1, 8'hAA, 8'h55, 3'd5, 1'b1, acc);
    check("full_pop_noacc", 32'(acc), 32'd0);
    cycle(1'b1, 8'hAA, 8'h55, 3'd5, 1'b1, acc);
    check("full_next_acc", 32'(acc), 32'd1);
    drain();

    // Random streaming with 50% out_ready.
    out_start = n_out;
    acc_cnt = 0;
    pa = 8'($urandom); pb = 8'($urandom); po = 3'($urandom);
    for (int c = 0; c < 400 && acc_cnt < 16; c++) begin
      cycle(1'($urandom_range(0, 3) != 0), pa, pb, po, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        acc_cnt++;
        pa = 8'($urandom); pb = 8'($urandom); po = 3'($urandom);
      end
    end
    check("stream_accepts", 32'(acc_cnt), 32'd16);
    drain();
    check("stream_outputs", 32'(n_out - out_start), 32'd16);

    // Asynchronous reset with two beats held.
    cycle(1'b1, 8'h5A, 8'h00, 3'd7, 1'b0, acc);
    cycle(1'b1, 8'h0F, 8'hF0, 3'd1, 1'b0, acc);
    cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, acc);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", 32'({bus.out_valid, bus.y, bus.y_zero, bus.y_ones}), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    stalled = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 8'h33, 8'h0F, 3'd0, 1'b1, acc);
    check("post_rst_acc", 32'(acc), 32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
